tx_interface: RTL

UART transmit-side interface, the counterpart of the receive interface. It buffers bytes written by the host into an internal FIFO and serialises them onto TX_Pin_Out as 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit). Consecutive bytes go out back-to-back with no idle gap. It sits between the host/top control logic and the UART TX pin.

---
 rtl/tx_interface.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/tx_interface.sv
// UART transmit interface: host bytes are queued in a small FIFO and shifted
// out as 8N1 frames, LSB first, with back-to-back frames sent without a gap.
module tx_interface #(
   parameter int BAUD_DIV = 434,
   parameter int FIFO_AW  = 4
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       Write_Req_Sig,
   input  logic [7:0] FIFO_Write_Data,
   output logic       Full_Sig,
   output logic       Empty_Sig,
   output logic       TX_Busy_Sig,
   output logic       TX_Pin_Out
);

   // state  | meaning
   // IDLE   | line high, waiting for a queued byte
   // START  | start bit (low) on the line
   // DATA   | eight data bits, LSB first
   // STOP   | stop bit (high); may chain straight into the next START

   localparam int DEPTH = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0] CNT_FULL  = (FIFO_AW+1)'(DEPTH);
   localparam logic [15:0]      BAUD_LAST = 16'(BAUD_DIV - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [7:0]         mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr;
   logic [FIFO_AW-1:0] rd_ptr;
   logic [FIFO_AW:0]   fifo_cnt;
   logic [7:0]         head_byte;
   logic               push;
   logic               pop;
   logic               cnt_nz;

   logic [15:0] baud_cnt;
   logic        baud_done;
   logic [2:0]  bit_idx;
   logic [7:0]  shift_reg;
   logic        pin_q;
   logic        pin_nxt;
   logic        load;

   assign cnt_nz    = (fifo_cnt != '0);
   assign push      = Write_Req_Sig && (fifo_cnt != CNT_FULL);
   assign head_byte = mem[rd_ptr];
   assign baud_done = (baud_cnt == BAUD_LAST);

   assign Full_Sig   = (fifo_cnt == CNT_FULL);
   assign Empty_Sig  = !cnt_nz;
   assign TX_Pin_Out = pin_q;

   // FIFO storage carries no reset; only pointers and count define validity.
   always_ff @(posedge CLK) begin
      if (push) begin
         mem[wr_ptr] <= FIFO_Write_Data;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
            2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (cnt_nz) begin
               state_nxt = ST_START;
            end
         end
         ST_START: begin
            if (baud_done) begin
               state_nxt = ST_DATA;
            end
         end
         ST_DATA: begin
            if (baud_done && (bit_idx == 3'd7)) begin
               state_nxt = ST_STOP;
            end
         end
         ST_STOP: begin
            if (baud_done) begin
               state_nxt = cnt_nz ? ST_START : ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      load        = 1'b0;
      pin_nxt     = 1'b1;
      TX_Busy_Sig = 1'b0;
      case (state)
         ST_IDLE: begin
            load = cnt_nz;
         end
         ST_START: begin
            pin_nxt     = 1'b0;
            TX_Busy_Sig = 1'b1;
         end
         ST_DATA: begin
            pin_nxt     = shift_reg[0];
            TX_Busy_Sig = 1'b1;
         end
         ST_STOP: begin
            load        = baud_done && cnt_nz;
            TX_Busy_Sig = 1'b1;
         end
         default: begin
            load = 1'b0;
         end
      endcase
      pop = load;
   end

   // The pin is registered from the current state, so it trails the state by one cycle.
   always_ff @(posedge CLK) begin
      if (RST) begin
         baud_cnt  <= '0;
         bit_idx   <= '0;
         shift_reg <= '0;
         pin_q     <= 1'b1;
      end else begin
         pin_q <= pin_nxt;

         if (load || (state == ST_IDLE) || baud_done) begin
            baud_cnt <= '0;
         end else begin
            baud_cnt <= baud_cnt + 16'd1;
         end

         if (state == ST_START) begin
            bit_idx <= '0;
         end else if ((state == ST_DATA) && baud_done) begin
            bit_idx <= bit_idx + 3'd1;
         end

         if (load) begin
            shift_reg <= head_byte;
         end else if ((state == ST_DATA) && baud_done) begin
            shift_reg <= {1'b0, shift_reg[7:1]};
         end
      end
   end

endmodule
